// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester (IFU, LSU) front end to a single memory port.
//
// One transaction in flight at a time. IDLE grants one requester (round-robin
// on contention), ISSUE presents the request to memory until accepted, WAIT
// collects the response (or times out), and RESP pulses the owner's resp_valid.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_ifu_req_valid/o_ifu_req_ready, i_ifu_addr
//   o_ifu_resp_valid, o_ifu_rdata     32-bit fetch word (half chosen by addr[2])
//   i_lsu_req_valid/o_lsu_req_ready, i_lsu_addr, i_lsu_wen, i_lsu_wdata, i_lsu_wmask
//   o_lsu_resp_valid, o_lsu_rdata     64-bit load data, 0 for stores
//   o_mem_req_valid/i_mem_req_ready, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask
//   i_mem_resp_valid, i_mem_rdata     response, no backpressure
//   o_busy                       not IDLE
//   o_protocol_err               sticky: stray response or response timeout
module mem_arbiter #(
    parameter int MEM_LAT_MAX = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ifu_req_valid,
    output logic        o_ifu_req_ready,
    input  logic [31:0] i_ifu_addr,
    output logic        o_ifu_resp_valid,
    output logic [31:0] o_ifu_rdata,
    input  logic        i_lsu_req_valid,
    output logic        o_lsu_req_ready,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_wen,
    input  logic [63:0] i_lsu_wdata,
    input  logic [7:0]  i_lsu_wmask,
    output logic        o_lsu_resp_valid,
    output logic [63:0] o_lsu_rdata,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [63:0] o_mem_wdata,
    output logic [7:0]  o_mem_wmask,
    input  logic        i_mem_resp_valid,
    input  logic [63:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_protocol_err
);

    // Counter only needs to reach MEM_LAT_MAX-1: the cycle it would pass that
    // without a response is the timeout cycle.
    localparam int CNT_W = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic               r_last_lsu;     // last grant went to LSU
    logic               r_owner_lsu;
    logic [31:0]        r_addr;
    logic               r_wen;
    logic [63:0]        r_wdata;
    logic [7:0]         r_wmask;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_ifu_resp_valid;
    logic               r_lsu_resp_valid;
    logic [31:0]        r_ifu_rdata;
    logic [63:0]        r_lsu_rdata;

    logic               w_idle;
    logic               w_gnt_ifu;
    logic               w_gnt_lsu;
    logic               w_timeout;
    logic [63:0]        w_resp_data;

    assign w_idle    = (r_state == S_IDLE) && !i_rst;
    // On contention the requester not served last wins.
    assign w_gnt_ifu = w_idle && i_ifu_req_valid && (!i_lsu_req_valid || r_last_lsu);
    assign w_gnt_lsu = w_idle && i_lsu_req_valid && (!i_ifu_req_valid || !r_last_lsu);
    assign w_timeout = (r_cnt == CNT_W'(MEM_LAT_MAX - 1));
    // A timed-out transaction completes with zero data.
    assign w_resp_data = i_mem_resp_valid ? i_mem_rdata : 64'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_last_lsu       <= 1'b0;
            r_owner_lsu      <= 1'b0;
            r_addr           <= '0;
            r_wen            <= 1'b0;
            r_wdata          <= '0;
            r_wmask          <= '0;
            r_cnt            <= '0;
            r_err            <= 1'b0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_ifu_rdata      <= '0;
            r_lsu_rdata      <= '0;
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mem_resp_valid) r_err <= 1'b1;
                    if (w_gnt_ifu) begin
                        r_addr      <= i_ifu_addr;
                        r_wen       <= 1'b0;
                        r_wdata     <= '0;
                        r_wmask     <= '0;
                        r_owner_lsu <= 1'b0;
                        r_last_lsu  <= 1'b0;
                        r_state     <= S_ISSUE;
                    end else if (w_gnt_lsu) begin
                        r_addr      <= i_lsu_addr;
                        r_wen       <= i_lsu_wen;
                        r_wdata     <= i_lsu_wdata;
                        r_wmask     <= i_lsu_wmask;
                        r_owner_lsu <= 1'b1;
                        r_last_lsu  <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_mem_resp_valid) r_err <= 1'b1;
                    if (i_mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_resp_valid || w_timeout) begin
                        if (!i_mem_resp_valid) r_err <= 1'b1;
                        // Response data is shaped for its owner here so the
                        // rdata outputs are plain registers that hold afterwards.
                        if (r_owner_lsu) begin
                            r_lsu_resp_valid <= 1'b1;
                            r_lsu_rdata      <= r_wen ? 64'd0 : w_resp_data;
                        end else begin
                            r_ifu_resp_valid <= 1'b1;
                            r_ifu_rdata      <= r_addr[2] ? w_resp_data[63:32] : w_resp_data[31:0];
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (i_mem_resp_valid) r_err <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced low for the whole reset assertion, not just after the
    // first reset edge.
    assign o_ifu_req_ready  = w_gnt_ifu;
    assign o_lsu_req_ready  = w_gnt_lsu;
    assign o_mem_req_valid  = !i_rst && (r_state == S_ISSUE);
    assign o_mem_addr       = i_rst ? 32'd0 : r_addr;
    assign o_mem_wen        = !i_rst && r_wen;
    assign o_mem_wdata      = i_rst ? 64'd0 : r_wdata;
    assign o_mem_wmask      = i_rst ? 8'd0 : r_wmask;
    assign o_ifu_resp_valid = !i_rst && r_ifu_resp_valid;
    assign o_lsu_resp_valid = !i_rst && r_lsu_resp_valid;
    assign o_ifu_rdata      = i_rst ? 32'd0 : r_ifu_rdata;
    assign o_lsu_rdata      = i_rst ? 64'd0 : r_lsu_rdata;
    assign o_busy           = !i_rst && (r_state != S_IDLE);
    assign o_protocol_err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all shadowed by a transaction-level model that is
// compared against every DUT output on each falling edge.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_valid, ifu_ready, ifu_resp;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_valid, lsu_ready, lsu_wen, lsu_resp;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_valid, mem_ready, mem_wen, mem_resp;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy, perr;

    int n_pass = 0;
    int n_chk  = 0;

    mem_arbiter #(.MEM_LAT_MAX(LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ifu_req_valid(ifu_valid), .o_ifu_req_ready(ifu_ready), .i_ifu_addr(ifu_addr),
        .o_ifu_resp_valid(ifu_resp), .o_ifu_rdata(ifu_rdata),
        .i_lsu_req_valid(lsu_valid), .o_lsu_req_ready(lsu_ready), .i_lsu_addr(lsu_addr),
        .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
        .o_lsu_resp_valid(lsu_resp), .o_lsu_rdata(lsu_rdata),
        .o_mem_req_valid(mem_valid), .i_mem_req_ready(mem_ready), .o_mem_addr(mem_addr),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
        .i_mem_resp_valid(mem_resp), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_protocol_err(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_known = 0;
    bit          m_act, m_own_lsu, m_iss, m_rsp, m_last_lsu, m_err;
    int          m_wait;
    logic [31:0] m_addr, m_ird;
    bit          m_wen;
    logic [63:0] m_wdata, m_lrd;
    logic [7:0]  m_wmask;

    function automatic bit exp_gnt_ifu();
        return !rst && !m_act && ifu_valid && (!lsu_valid || m_last_lsu);
    endfunction
    function automatic bit exp_gnt_lsu();
        return !rst && !m_act && lsu_valid && (!ifu_valid || !m_last_lsu);
    endfunction

    task automatic deliver(input logic [63:0] d);
        m_rsp = 1;
        if (m_own_lsu) m_lrd = m_wen ? 64'd0 : d;
        else           m_ird = m_addr[2] ? d[63:32] : d[31:0];
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1; m_act = 0; m_iss = 0; m_rsp = 0; m_last_lsu = 0; m_err = 0;
            m_ird = 0; m_lrd = 0; m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0; m_wait = 0;
        end else if (m_known) begin
            if (!m_act) begin
                if (mem_resp) m_err = 1;
                if (exp_gnt_ifu()) begin
                    m_act = 1; m_own_lsu = 0; m_iss = 0; m_last_lsu = 0;
                    m_addr = ifu_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
                end else if (exp_gnt_lsu()) begin
                    m_act = 1; m_own_lsu = 1; m_iss = 0; m_last_lsu = 1;
                    m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                end
            end else if (m_rsp) begin
                if (mem_resp) m_err = 1;
                m_act = 0; m_rsp = 0;
            end else if (!m_iss) begin
                if (mem_resp) m_err = 1;
                if (mem_ready) begin m_iss = 1; m_wait = 0; end
            end else begin
                m_wait++;
                if (mem_resp) deliver(mem_rdata);
                else if (m_wait >= LAT) begin m_err = 1; deliver(64'd0); end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_known) begin
            chk("ifu_req_ready", ifu_ready, exp_gnt_ifu());
            chk("lsu_req_ready", lsu_ready, exp_gnt_lsu());
            chk("mem_req_valid", mem_valid, !rst && m_act && !m_iss);
            if (rst) begin
                chk("mem_fields_rst", {mem_addr, mem_wmask, 7'd0, mem_wen}, 48'd0);
                chk("mem_wdata_rst", mem_wdata, 64'd0);
            end else if (m_act && !m_iss) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wen", mem_wen, m_wen);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_wmask", mem_wmask, m_wmask);
            end
            chk("ifu_resp_valid", ifu_resp, !rst && m_rsp && !m_own_lsu);
            chk("lsu_resp_valid", lsu_resp, !rst && m_rsp && m_own_lsu);
            chk("ifu_rdata", ifu_rdata, rst ? 32'd0 : m_ird);
            chk("lsu_rdata", lsu_rdata, rst ? 64'd0 : m_lrd);
            chk("busy", busy, !rst && m_act);
            chk("protocol_err", perr, m_err);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    // Auto-respond one cycle after each memory handshake until idle.
    task automatic drain();
        bit hs;
        int n = 0;
        ifu_valid = 0; lsu_valid = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            if (n == 30) begin chk("drain_timeout", busy, 0); break; end
            hs = mem_valid && mem_ready;
            tick(); mem_resp = hs; n++;
        end
        tick(); mem_resp = 0;
    endtask

    initial begin
        int g[4];
        int exp_g[4] = '{1, 0, 1, 0};   // 1 = LSU
        int ng, cyc;
        bit ri, rl, hs;

        rst = 1; ifu_valid = 0; ifu_addr = 0; lsu_valid = 0; lsu_addr = 0; lsu_wen = 0;
        lsu_wdata = 0; lsu_wmask = 0; mem_ready = 0; mem_resp = 0; mem_rdata = 0;
        tick(); tick();
        ifu_valid = 1; lsu_valid = 1;
        @(negedge clk);
        chk("rst_ifu_ready", ifu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", perr, 0);
        tick(); rst = 0; ifu_valid = 0; lsu_valid = 0;

        // Single fetch, minimum latency
        ifu_valid = 1; ifu_addr = 32'h8000_0004; mem_ready = 1;
        @(negedge clk); chk("fetch_accept", ifu_ready, 1);
        tick(); ifu_valid = 0;
        @(negedge clk); chk("fetch_issue", mem_valid, 1); chk("fetch_addr", mem_addr, 32'h8000_0004);
        tick(); mem_resp = 1; mem_rdata = 64'h1122_3344_5566_7788;
        tick(); mem_resp = 0;
        @(negedge clk);
        chk("fetch_resp_t3", ifu_resp, 1);
        chk("fetch_rdata", ifu_rdata, 32'h1122_3344);
        chk("fetch_lsu_quiet", lsu_resp, 0);
        tick();
        @(negedge clk); chk("fetch_pulse_end", ifu_resp, 0); chk("fetch_hold", ifu_rdata, 32'h1122_3344);

        // Timeout: four WAIT cycles with no response
        ifu_valid = 1; ifu_addr = 32'h8000_0000; mem_ready = 1;
        tick(); ifu_valid = 0;
        repeat (4) tick();
        @(negedge clk); chk("to_not_yet", ifu_resp, 0); chk("to_err_pre", perr, 0);
        tick();
        @(negedge clk);
        chk("to_resp", ifu_resp, 1);
        chk("to_rdata", ifu_rdata, 0);
        chk("to_err", perr, 1);
        tick();

        // Contention: LSU, IFU, LSU, IFU
        do_reset();
        ifu_valid = 1; ifu_addr = 32'h8000_0100; lsu_valid = 1; lsu_addr = 32'h8000_0200;
        lsu_wen = 0; mem_ready = 1; mem_rdata = 64'hA5A5_0000_1234_5678;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 60) begin
            @(negedge clk);
            ri = ifu_ready; rl = lsu_ready; hs = mem_valid && mem_ready;
            if (ri || rl) begin
                chk("no_double_grant", {ri, rl}, (rl ? 2'b01 : 2'b10));
                g[ng] = rl ? 1 : 0; ng++;
            end
            tick(); mem_resp = hs; cyc++;
        end
        chk("contention_count", ng, 4);
        for (int i = 0; i < ng; i++) chk($sformatf("grant%0d", i), g[i], exp_g[i]);
        drain();

        // Store with memory stalling three cycles
        lsu_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 1;
        lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_wmask = 8'h0F; mem_ready = 0;
        @(negedge clk); chk("st_accept", lsu_ready, 1);
        tick();
        lsu_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = '1; lsu_wmask = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_valid", mem_valid, 1);
            chk("st_addr", mem_addr, 32'h8000_0010);
            chk("st_wen", mem_wen, 1);
            chk("st_wdata", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
            chk("st_wmask", mem_wmask, 8'h0F);
            tick();
        end
        mem_ready = 1; tick();
        mem_resp = 1; mem_rdata = 64'h0123_4567_89AB_CDEF; tick();
        mem_resp = 0;
        @(negedge clk); chk("st_resp", lsu_resp, 1); chk("st_rdata", lsu_rdata, 0); chk("st_ifu_quiet", ifu_resp, 0);
        tick();

        // Spurious response in IDLE
        do_reset();
        mem_resp = 1;
        @(negedge clk); chk("sp_no_ifu", ifu_resp, 0); chk("sp_no_lsu", lsu_resp, 0);
        tick(); mem_resp = 0;
        @(negedge clk); chk("sp_err", perr, 1);
        repeat (3) tick();
        @(negedge clk); chk("sp_sticky", perr, 1); chk("sp_still_no_lsu", lsu_resp, 0);

        // Reset during WAIT, then a stale response
        do_reset();
        lsu_valid = 1; lsu_addr = 32'h8000_0020; lsu_wen = 0; mem_ready = 1;
        tick(); lsu_valid = 0;
        tick();
        rst = 1;
        @(negedge clk); chk("rm_busy_in_rst", busy, 0);
        tick(); rst = 0; mem_resp = 1; mem_rdata = 64'h5555_6666_7777_8888;
        @(negedge clk); chk("rm_no_resp", lsu_resp, 0); chk("rm_busy", busy, 0); chk("rm_err_pre", perr, 0);
        tick(); mem_resp = 0;
        @(negedge clk); chk("rm_err", perr, 1); chk("rm_no_resp2", lsu_resp, 0); chk("rm_lsu_rdata", lsu_rdata, 0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(299) == 0);
            ifu_valid = $urandom_range(1);
            ifu_addr  = $urandom;
            lsu_valid = $urandom_range(1);
            lsu_addr  = $urandom;
            lsu_wen   = $urandom_range(1);
            lsu_wdata = {$urandom, $urandom};
            lsu_wmask = 8'($urandom);
            mem_ready = ($urandom_range(2) != 0);
            mem_resp  = (m_act && m_iss && !m_rsp) ? ($urandom_range(2) == 0) : ($urandom_range(59) == 0);
            mem_rdata = {$urandom, $urandom};
            tick();
        end
        rst = 0; mem_resp = 0; ifu_valid = 0; lsu_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT_MAX, default 255, response-timeout limit in cycles after the memory request is accepted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ifu_req_valid  in  1  instruction fetch request.
REQ-005 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-006 ifu_addr  in  32  fetch byte address.
REQ-007 ifu_resp_valid  out  1  one-cycle pulse, fetch data valid.
REQ-008 ifu_rdata  out  32  fetched instruction.
REQ-009 lsu_req_valid  in  1  load/store request.
REQ-010 lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-011 lsu_addr, lsu_wen, lsu_wdata, lsu_wmask  in  32/1/64/8  address, write enable, write data, byte mask.
REQ-012 lsu_resp_valid  out  1  one-cycle pulse, load data or store acknowledge.
REQ-013 lsu_rdata  out  64  load data.
REQ-014 mem_req_valid  out  1, and mem_req_ready  in  1  memory request handshake.
REQ-015 mem_addr, mem_wen, mem_wdata, mem_wmask  out  32/1/64/8  memory request fields.
REQ-016 mem_resp_valid  in  1, and mem_rdata  in  64  memory response; there is no backpressure on the response.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 protocol_err  out  1  sticky error flag.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with at most one transaction outstanding.
REQ-020 In IDLE, ready SHALL be asserted combinationally to exactly one valid requester; when both requesters are valid, the grant goes to the one not granted last (round-robin); last_grant resets to IFU, so the first contention grants LSU.
REQ-021 On acceptance (valid && ready), the FSM SHALL latch addr, wen, wdata, wmask and owner, then go to ISSUE; IFU requests are latched with wen=0 and wmask=0.
REQ-022 In ISSUE, mem_req_valid SHALL be 1 and the request fields SHALL be stable until mem_req_ready; on the handshake the FSM goes to WAIT and clears the timeout counter.
REQ-023 In WAIT, on mem_resp_valid the FSM SHALL latch mem_rdata and go to RESP.
REQ-024 In RESP, exactly one owner's resp_valid SHALL be 1 for one cycle, then the FSM returns to IDLE; no request is accepted in RESP.
REQ-025 ifu_rdata SHALL be mem_rdata[63:32] when latched addr[2]=1, else mem_rdata[31:0].
REQ-026 lsu_rdata SHALL be the latched mem_rdata for loads and 0 for stores; a store still produces lsu_resp_valid.
REQ-027 Non-owner resp outputs SHALL be 0, and the rdata outputs SHALL hold their last value outside RESP.
REQ-028 Minimum latency, with mem_req_ready=1 and the memory responding the cycle after issue: accept at T, issue at T+1, mem_resp at T+2, requester resp at T+3.
REQ-029 A mem_resp_valid in IDLE, ISSUE or RESP SHALL be ignored and SHALL set protocol_err.
REQ-030 If WAIT exceeds MEM_LAT_MAX cycles, the FSM SHALL set protocol_err, pulse owner resp_valid with rdata=0, and return to IDLE.
REQ-031 Requester valid dropping before acceptance SHALL be legal; after acceptance the request inputs are not sampled.
REQ-032 Addresses SHALL be forwarded unchanged; alignment is not checked.

Reset
REQ-033 On rst the FSM SHALL go to IDLE, last_grant to IFU, and the counter, busy and protocol_err to 0.
REQ-034 While rst=1, all valid and ready outputs SHALL be 0, mem fields 0 and rdata outputs 0.
REQ-035 Reset mid-transaction SHALL discard the transaction with no resp pulse; a later stale mem_resp_valid sets protocol_err.

Verification
REQ-036 Single fetch: ifu addr 0x80000004, mem returns 0x11223344_55667788 one cycle after issue -> ifu_resp_valid at T+3, ifu_rdata 0x11223344.
REQ-037 Contention: both requesters held valid for 4 transactions -> grant order LSU, IFU, LSU, IFU; no double grant.
REQ-038 Store with mem_req_ready low 3 cycles: addr 0x80000010, wdata 0xDEADBEEF_CAFEF00D, wmask 0x0F -> request fields stable throughout, lsu_resp_valid pulse, lsu_rdata 0.
REQ-039 Spurious mem_resp_valid in IDLE -> protocol_err=1 and stays 1; no resp pulse.
REQ-040 Timeout: MEM_LAT_MAX=4, no response -> after 4 WAIT cycles the owner gets a resp pulse with rdata 0 and protocol_err=1.
REQ-041 rst asserted in WAIT, then mem_resp_valid -> no resp pulse, busy=0, protocol_err=1.
